mem_load_ctrl: RTL and testbench

Boot-load controller for the 32-byte program/data RAM of the 8-bit RISC processor. It accepts a byte stream from a host over a valid/ready handshake and writes it sequentially into RAM through the RAM's external write port (`ewr`/`ead`/`edat`). It holds the CPU in load mode (`cpu_run`=0) while loading, then releases it. It sits between the host/UART receiver and the RAM. Its `cpu_run` output drives the RAM's and core's run/load input.

---
 rtl/risc_pkg.sv | 25 ++
 rtl/mem_load_if.sv | 34 +++
 rtl/mem_ld_cksum.sv | 50 +++++
 rtl/mem_load_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_load_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_pkg
//  Description : Shared constants for the 8-bit RISC processor: data/address
//                widths, program RAM depth and the mem_load_ctrl state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

   localparam int DW        = 8;          // data width
   localparam int AW        = 5;          // RAM address width
   localparam int RAM_DEPTH = 1 << AW;    // program/data RAM depth in bytes

   // Boot-load controller state encoding
   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_CHK    = 3'd2;
   localparam logic [2:0] ST_SETTLE = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/mem_load_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_if
//  Description : Host byte stream (valid/ready) plus RAM external write port
//                used by the boot-load controller.
//  Signals     : s_valid, s_data  host -> controller byte stream
//                s_ready          controller -> host accept
//                ewr, ead, edat   controller -> RAM external write port
//  Modports    : master - host/RAM side (drives the stream)
//                slave  - controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_load_if;
   import risc_pkg::*;

   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          ewr;
   logic [AW-1:0] ead;
   logic [DW-1:0] edat;

   modport master (
      output s_valid, s_data,
      input  s_ready, ewr, ead, edat
   );

   modport slave (
      input  s_valid, s_data,
      output s_ready, ewr, ead, edat
   );

endinterface
`default_nettype wire

// File: rtl/mem_ld_cksum.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ld_cksum
//  Description : 8-bit modular accumulator for the boot-load checksum.
//                Only instantiated when MEM_LOAD_CHECKSUM_EN is defined.
//  Ports       : clk, rst        clock, asynchronous active-low reset
//                clr             clear the running sum (takes priority)
//                add             accumulate din into the sum
//                din             byte to accumulate / test
//                zero_next       1 when (sum + din) mod 2^DW == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ld_cksum
   import risc_pkg::*;
(
   input  wire          clk,
   input  wire          rst,
   input  wire          clr,
   input  wire          add,
   input  wire [DW-1:0] din,
   output logic         zero_next
);

   logic [DW-1:0] sum_q;
   logic [DW-1:0] sum_d;
   logic [DW-1:0] sum_plus;

   // Carry out is discarded: the checksum is a modulo-256 sum.
   assign sum_plus  = sum_q + din;
   assign zero_next = (sum_plus == '0);

   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (add) begin
         sum_d = sum_plus;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_ctrl
//  Description : Boot-load controller. Streams LOAD_LEN host bytes into the
//                program RAM through its external write port while holding
//                the CPU in load mode, then releases the CPU.
//  Ports       : clk, rst         clock, asynchronous active-low reset
//                start            begin a load (IDLE/ERR only)
//                halt             return to IDLE from any state
//                bus (slave)      host stream + RAM external write port
//                cpu_run          1 = CPU runs, 0 = load mode
//                busy             LOAD, SETTLE or CHK
//                err              checksum failure, sticky until next start
//  Parameters  : LOAD_LEN         data bytes per load, 1..2^AW
//  Options     : MEM_LOAD_CHECKSUM_EN - require a trailing checksum byte so
//                that the modulo-256 sum of data + checksum equals 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_load_ctrl
   import risc_pkg::*;
#(
   parameter int LOAD_LEN = 32
)
(
   input  wire        clk,
   input  wire        rst,
   input  wire        start,
   input  wire        halt,
   mem_load_if.slave  bus,
   output logic       cpu_run,
   output logic       busy,
   output logic       err
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(LOAD_LEN - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic          ewr_q,   ewr_d;
   logic [AW-1:0] ead_q,   ead_d;
   logic [DW-1:0] edat_q,  edat_d;

   logic          s_ready;
   logic          xfer;

   assign s_ready     = (state_q == ST_LOAD) || (state_q == ST_CHK);
   assign xfer        = bus.s_valid && s_ready;
   assign bus.s_ready = s_ready;
   assign bus.ewr     = ewr_q;
   assign bus.ead     = ead_q;
   assign bus.edat    = edat_q;

   assign cpu_run = (state_q == ST_RUN);
   assign busy    = (state_q == ST_LOAD) || (state_q == ST_SETTLE) ||
                    (state_q == ST_CHK);

`ifdef MEM_LOAD_CHECKSUM_EN
   logic start_acc;
   logic cksum_zero;
   logic err_q, err_d;

   assign start_acc = !halt && start &&
                      ((state_q == ST_IDLE) || (state_q == ST_ERR));

   // Both data and checksum bytes are accumulated; the sum is only
   // inspected on the checksum transfer itself.
   mem_ld_cksum u_cksum (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_acc),
      .add       (xfer),
      .din       (bus.s_data),
      .zero_next (cksum_zero)
   );

   always_comb begin
      err_d = err_q;
      if (start_acc) begin
         err_d = 1'b0;
      end else if (!halt && xfer && (state_q == ST_CHK) && !cksum_zero) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ewr_d   = 1'b0;
      ead_d   = ead_q;
      edat_d  = edat_q;
      // halt wins over everything, including a transfer in the same cycle.
      if (halt) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_ERR: begin
               if (start) begin
                  state_d = ST_LOAD;
                  addr_d  = '0;
               end
            end
            ST_LOAD: begin
               if (xfer) begin
                  ewr_d  = 1'b1;
                  ead_d  = addr_q;
                  edat_d = bus.s_data;
                  // Wraps to 0 after 2^AW-1; the value is unused afterwards.
                  addr_d = addr_q + 1'b1;
                  if (addr_q == LAST_ADDR) begin
`ifdef MEM_LOAD_CHECKSUM_EN
                     state_d = ST_CHK;
`else
                     state_d = ST_SETTLE;
`endif
                  end
               end
            end
`ifdef MEM_LOAD_CHECKSUM_EN
            ST_CHK: begin
               // Checksum byte is consumed but never written to RAM.
               if (xfer) begin
                  state_d = cksum_zero ? ST_SETTLE : ST_ERR;
               end
            end
`endif
            // One extra load-mode cycle so the RAM captures the last write.
            ST_SETTLE: state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         ewr_q   <= 1'b0;
         ead_q   <= '0;
         edat_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ewr_q   <= ewr_d;
         ead_q   <= ead_d;
         edat_q  <= edat_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_load_ctrl
//  Description : Directed self-checking bench for mem_load_ctrl. Drives a
//                LOAD_LEN=32 instance and, when MEM_LOAD_CHECKSUM_EN is
//                defined, a second LOAD_LEN=4 instance with checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_load_ctrl;
   import risc_pkg::*;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic start = 1'b0;
   logic halt  = 1'b0;
   logic cpu_run, busy, err;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ram [RAM_DEPTH];

   mem_load_if bus ();

   always #5 clk = ~clk;

   mem_load_ctrl #(.LOAD_LEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .halt    (halt),
      .bus     (bus),
      .cpu_run (cpu_run),
      .busy    (busy),
      .err     (err)
   );

   // RAM model: captures on the rising edge while it still sees load mode.
   always @(posedge clk) begin
      if (bus.ewr && !cpu_run) ram[bus.ead] <= bus.edat;
   end

`ifdef MEM_LOAD_CHECKSUM_EN
   logic start2 = 1'b0;
   logic cpu_run2, busy2, err2;
   mem_load_if bus2 ();

   mem_load_ctrl #(.LOAD_LEN(4)) dut2 (
      .clk     (clk),
      .rst     (rst),
      .start   (start2),
      .halt    (halt),
      .bus     (bus2),
      .cpu_run (cpu_run2),
      .busy    (busy2),
      .err     (err2)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Sends n bytes (i ^ pat); optional idle cycle between bytes.
   task automatic send_bytes(input int n, input bit gap, input logic [7:0] pat);
      for (int i = 0; i < n; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(i) ^ pat;
         step();
         chk("ewr_xfer", 32'(bus.ewr), 1);
         chk("ead_xfer", 32'(bus.ead), i);
         chk("edat_xfer", 32'(bus.edat), 32'(8'(i) ^ pat));
         if (gap && (i != n - 1)) begin
            bus.s_valid = 1'b0;
            step();
            chk("ewr_gap", 32'(bus.ewr), 0);
            chk("ready_gap", 32'(bus.s_ready), 1);
         end
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic check_ram(input logic [7:0] pat);
      for (int i = 0; i < RAM_DEPTH; i++) begin
         chk("ram_readback", 32'(ram[i]), 32'(8'(i) ^ pat));
      end
   endtask

   // Finishes a full load: SETTLE cycle then RUN.
   task automatic finish_load();
      chk("settle_cpu_run", 32'(cpu_run), 0);
      chk("settle_busy", 32'(busy), 1);
      chk("settle_ready", 32'(bus.s_ready), 0);
      step();
      chk("run_cpu_run", 32'(cpu_run), 1);
      chk("run_busy", 32'(busy), 0);
      chk("run_ewr", 32'(bus.ewr), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
`ifdef MEM_LOAD_CHECKSUM_EN
      bus2.s_valid = 1'b0;
      bus2.s_data  = '0;
`endif
      repeat (2) step();

      // Reset values
      chk("rst_ready", 32'(bus.s_ready), 0);
      chk("rst_ewr", 32'(bus.ewr), 0);
      chk("rst_ead", 32'(bus.ead), 0);
      chk("rst_edat", 32'(bus.edat), 0);
      chk("rst_cpu_run", 32'(cpu_run), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      rst = 1'b1;
      step();

      // s_valid in IDLE is ignored
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
      step();
      chk("idle_ewr", 32'(bus.ewr), 0);
      chk("idle_ready", 32'(bus.s_ready), 0);
      bus.s_valid = 1'b0;

      // Back-to-back load of 00..1F
      do_start();
      chk("load_ready", 32'(bus.s_ready), 1);
      chk("load_busy", 32'(busy), 1);
      send_bytes(32, 1'b0, 8'h00);
      finish_load();
      check_ram(8'h00);

      // start in RUN ignored; halt beats start
      start = 1'b1;
      step();
      start = 1'b0;
      chk("run_start_ignored", 32'(cpu_run), 1);
      start = 1'b1;
      halt  = 1'b1;
      step();
      start = 1'b0;
      halt  = 1'b0;
      chk("halt_cpu_run", 32'(cpu_run), 0);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_ready", 32'(bus.s_ready), 0);
      step();
      chk("halt_stays_idle", 32'(bus.s_ready), 0);

      // Load with a bubble between every byte
      do_start();
      send_bytes(32, 1'b1, 8'h5A);
      finish_load();
      check_ram(8'h5A);

      // halt after 10 bytes, with a byte offered in the halt cycle
      halt = 1'b1;
      step();
      halt = 1'b0;
      do_start();
      send_bytes(10, 1'b0, 8'h00);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h77;
      halt        = 1'b1;
      step();
      halt        = 1'b0;
      bus.s_valid = 1'b0;
      chk("abort_ready", 32'(bus.s_ready), 0);
      chk("abort_ewr", 32'(bus.ewr), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_cpu_run", 32'(cpu_run), 0);
      do_start();
      send_bytes(32, 1'b0, 8'hC3);
      finish_load();
      check_ram(8'hC3);

      // Asynchronous reset mid-load after 5 bytes
      halt = 1'b1;
      step();
      halt = 1'b0;
      do_start();
      send_bytes(5, 1'b0, 8'h00);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h33;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ewr", 32'(bus.ewr), 0);
      chk("arst_ead", 32'(bus.ead), 0);
      chk("arst_edat", 32'(bus.edat), 0);
      chk("arst_ready", 32'(bus.s_ready), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_cpu_run", 32'(cpu_run), 0);
      #2;
      rst = 1'b1;
      step();
      chk("post_arst_ready", 32'(bus.s_ready), 0);
      chk("post_arst_ewr", 32'(bus.ewr), 0);
      bus.s_valid = 1'b0;

`ifdef MEM_LOAD_CHECKSUM_EN
      // Good checksum: 01+02+03+04+F6 = 0x100
      for (int pass = 0; pass < 2; pass++) begin
         start2 = 1'b1;
         step();
         start2 = 1'b0;
         chk("ck_err_cleared", 32'(err2), 0);
         for (int i = 1; i <= 4; i++) begin
            bus2.s_valid = 1'b1;
            bus2.s_data  = 8'(i);
            step();
            chk("ck_ewr", 32'(bus2.ewr), 1);
            chk("ck_ead", 32'(bus2.ead), i - 1);
         end
         chk("ck_chk_ready", 32'(bus2.s_ready), 1);
         chk("ck_chk_busy", 32'(busy2), 1);
         bus2.s_data = (pass == 0) ? 8'hF6 : 8'hF5;
         step();
         bus2.s_valid = 1'b0;
         chk("ck_sum_not_written", 32'(bus2.ewr), 0);
         if (pass == 0) begin
            chk("ck_settle_busy", 32'(busy2), 1);
            step();
            chk("ck_good_run", 32'(cpu_run2), 1);
            chk("ck_good_err", 32'(err2), 0);
            halt = 1'b1;
            step();
            halt = 1'b0;
         end else begin
            chk("ck_bad_err", 32'(err2), 1);
            chk("ck_bad_cpu_run", 32'(cpu_run2), 0);
            chk("ck_bad_busy", 32'(busy2), 0);
            step();
            chk("ck_err_sticky", 32'(err2), 1);
            start2 = 1'b1;
            step();
            start2 = 1'b0;
            chk("ck_start_clears_err", 32'(err2), 0);
            chk("ck_restart_busy", 32'(busy2), 1);
         end
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
